// File: rtl/ram_driver_if.sv
// Bundle of client-side and PSRAM-side signals for ram_driver.
// Command: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len/cmd_ublb. Write data: wr_data/wr_next.
// Read data: rd_data/rd_strobe. RAM bus: ram_clk, ram_a, ram_d_*, ram_ce1/ce2/oe/we/adv/ub/lb.
interface ram_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [22:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [1:0]  cmd_ublb;
  logic [15:0] wr_data;
  logic        wr_next;
  logic [15:0] rd_data;
  logic        rd_strobe;
  logic        ram_clk;
  logic [22:0] ram_a;
  logic [15:0] ram_d_out;
  logic        ram_d_oe;
  logic [15:0] ram_d_in;
  logic        ram_ce1;
  logic        ram_ce2;
  logic        ram_oe;
  logic        ram_we;
  logic        ram_adv;
  logic        ram_ub;
  logic        ram_lb;

  // master: the bus initiator (ram_driver itself)
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_ublb, wr_data, ram_d_in,
    output cmd_ready, wr_next, rd_data, rd_strobe,
    output ram_clk, ram_a, ram_d_out, ram_d_oe,
    output ram_ce1, ram_ce2, ram_oe, ram_we, ram_adv, ram_ub, ram_lb
  );

  // slave: the client plus the PSRAM device (bench side)
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_ublb, wr_data, ram_d_in,
    input  cmd_ready, wr_next, rd_data, rd_strobe,
    input  ram_clk, ram_a, ram_d_out, ram_d_oe,
    input  ram_ce1, ram_ce2, ram_oe, ram_we, ram_adv, ram_ub, ram_lb
  );
endinterface

// File: rtl/ram_driver.sv
// Synchronous-burst PSRAM bus initiator: turns one read/write burst command into a full RAM bus cycle.
// Latency: burst takes 2*(1+LATENCY+len)*CLK_DIV mclk cycles; read word k strobes 2*(1+LATENCY+k)*CLK_DIV after accept.
// Backpressure: cmd_ready only in IDLE, no queuing; write data is paced by wr_next, reads are never stalled.
// Ports: mclk/reset (async, active-high); bus = ram_driver_if.master carrying the command, write-data,
//        read-data and PSRAM bus signals (all bus outputs registered).
module ram_driver #(
  parameter int CLK_DIV = 4,  // mclk cycles per ram_clk half-period, 2..255
  parameter int LATENCY = 3   // rises from address-latch rise to first data rise, 1..7
) (
  input  logic          mclk,
  input  logic          reset,
  ram_driver_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  // The fall after this rise is the one right before the first data rise.
  localparam logic [4:0] LAT_RISE   = 5'(LATENCY);
  localparam logic [4:0] FIRST_DATA = 5'(LATENCY + 1);

  state_t      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  rise_cnt_q, rise_cnt_d;
  logic        write_q, write_d;
  logic [3:0]  len_q, len_d;
  logic        ram_clk_q, ram_clk_d;
  logic [22:0] a_q, a_d;
  logic [15:0] d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        ce1_q, ce1_d, ce2_q, ce2_d, oe_q, oe_d, we_q, we_d;
  logic        adv_q, adv_d, ub_q, ub_d, lb_q, lb_d;
  logic        wr_next_q, wr_next_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic [15:0] rd_data_q, rd_data_d;

  logic        tick, rise, fall;
  logic        load_wr, end_burst;
  logic [4:0]  last_rise;

  // ram_clk edge generation: one toggle every CLK_DIV mclk edges while busy.
  assign tick      = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
  assign rise      = tick && !ram_clk_q;
  assign fall      = tick && ram_clk_q;
  assign last_rise = FIRST_DATA + {1'b0, len_q};

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    rise_cnt_d  = rise_cnt_q;
    write_d     = write_q;
    len_d       = len_q;
    ram_clk_d   = ram_clk_q;
    a_d         = a_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    ce1_d       = ce1_q;
    ce2_d       = ce2_q;
    oe_d        = oe_q;
    we_d        = we_q;
    adv_d       = adv_q;
    ub_d        = ub_q;
    lb_d        = lb_q;
    wr_next_d   = 1'b0;
    rd_strobe_d = 1'b0;
    rd_data_d   = rd_data_q;
    load_wr     = 1'b0;
    end_burst   = 1'b0;

    if (state_q != IDLE) begin
      div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
      if (rise) begin
        ram_clk_d  = 1'b1;
        rise_cnt_d = rise_cnt_q + 5'd1;
      end
      if (fall) begin
        ram_clk_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = ADDR;
          write_d    = bus.cmd_write;
          len_d      = bus.cmd_len;
          div_cnt_d  = 8'd0;
          rise_cnt_d = 5'd0;
          ram_clk_d  = 1'b0;
          ce1_d      = 1'b0;
          ce2_d      = 1'b1;
          adv_d      = 1'b0;
          a_d        = bus.cmd_addr;
          we_d       = ~bus.cmd_write;
          if (bus.cmd_write) begin
            {ub_d, lb_d} = ~bus.cmd_ublb;
          end else begin
            {ub_d, lb_d} = 2'b00;
          end
        end
      end
      ADDR: begin
        // Only rise #1 happens in ADDR, so the first fall ends the address phase.
        if (fall) begin
          adv_d = 1'b1;
          oe_d  = write_q;  // reads enable the PSRAM output drivers for the rest of the burst
          if (LATENCY == 1) begin
            // The address-latch fall is already the fall before the first data rise.
            state_d = DATA;
            load_wr = write_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (fall && rise_cnt_q == LAT_RISE) begin
          state_d = DATA;
          load_wr = write_q;
        end
      end
      DATA: begin
        // Every fall in DATA follows a data rise: capture the read word, then either
        // finish or present the next write word for the coming rise.
        if (fall) begin
          if (!write_q) begin
            rd_data_d   = bus.ram_d_in;
            rd_strobe_d = 1'b1;
          end
          if (rise_cnt_q == last_rise) begin
            end_burst = 1'b1;
          end else begin
            load_wr = write_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_wr) begin
      d_out_d   = bus.wr_data;
      d_oe_d    = 1'b1;
      wr_next_d = 1'b1;
    end

    // ram_a and ram_d_out keep their values; the PSRAM advances the address itself.
    if (end_burst) begin
      state_d = IDLE;
      ce1_d   = 1'b1;
      ce2_d   = 1'b0;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      adv_d   = 1'b1;
      ub_d    = 1'b1;
      lb_d    = 1'b1;
      d_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_cnt_q   <= 8'd0;
      rise_cnt_q  <= 5'd0;
      write_q     <= 1'b0;
      len_q       <= 4'd0;
      ram_clk_q   <= 1'b0;
      a_q         <= 23'd0;
      d_out_q     <= 16'd0;
      d_oe_q      <= 1'b0;
      ce1_q       <= 1'b1;
      ce2_q       <= 1'b0;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      adv_q       <= 1'b1;
      ub_q        <= 1'b1;
      lb_q        <= 1'b1;
      wr_next_q   <= 1'b0;
      rd_strobe_q <= 1'b0;
      rd_data_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      rise_cnt_q  <= rise_cnt_d;
      write_q     <= write_d;
      len_q       <= len_d;
      ram_clk_q   <= ram_clk_d;
      a_q         <= a_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      ce1_q       <= ce1_d;
      ce2_q       <= ce2_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      adv_q       <= adv_d;
      ub_q        <= ub_d;
      lb_q        <= lb_d;
      wr_next_q   <= wr_next_d;
      rd_strobe_q <= rd_strobe_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_next   = wr_next_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_strobe = rd_strobe_q;
  assign bus.ram_clk   = ram_clk_q;
  assign bus.ram_a     = a_q;
  assign bus.ram_d_out = d_out_q;
  assign bus.ram_d_oe  = d_oe_q;
  assign bus.ram_ce1   = ce1_q;
  assign bus.ram_ce2   = ce2_q;
  assign bus.ram_oe    = oe_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_adv   = adv_q;
  assign bus.ram_ub    = ub_q;
  assign bus.ram_lb    = lb_q;

endmodule
